global_avg_pool_stream: RTL and testbench



---
 rtl/global_avg_pool_stream.sv | 149 ++++++++++++++
 tb/tb_global_avg_pool_stream.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/global_avg_pool_stream.sv
// global_avg_pool_stream: streaming per-channel global average pool (AdaptiveAvgPool2d -> 1x1).
// Rev 1.0 - planar/interleaved input order, signed/unsigned data, floor or round-half-up division.
`default_nettype none

module global_avg_pool_stream #(
   parameter int DATA_WIDTH = 16,
   parameter int IN_HEIGHT  = 7,
   parameter int IN_WIDTH   = 7,
   parameter int CHANNELS   = 16,
   parameter int CH_ORDER   = 0,
   parameter int SIGNED     = 0,
   parameter int ROUND      = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] out_channel,
   output logic                  out_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy
);

   localparam int N     = IN_HEIGHT * IN_WIDTH;
   localparam int ACC_W = DATA_WIDTH + $clog2(N);
   localparam int PIX_W = (N > 1) ? $clog2(N) : 1;
   localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int NUM_W = ACC_W + 2;

   localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(N - 1);
   localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);
   localparam logic [NUM_W-1:0] DEN      = (ROUND != 0) ? NUM_W'(2 * N) : NUM_W'(N);

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      CALC  = 2'd1,
      OUT   = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [ACC_W-1:0] acc [CHANNELS];
   logic [PIX_W-1:0] pix_cnt;
   logic [CH_W-1:0]  ch_cnt;
   logic [CH_W-1:0]  out_idx;

   logic             accept;
   logic             last_elem;
   logic [ACC_W-1:0] in_ext;
   logic [NUM_W-1:0] num;
   logic [NUM_W-1:0] mag;
   logic [NUM_W-1:0] quo_mag;
   logic             neg;
   logic [DATA_WIDTH-1:0] avg;

   assign in_ready  = (state == ACCUM);
   assign out_valid = (state == OUT);
   assign accept    = in_valid && in_ready;
   assign last_elem = (pix_cnt == PIX_LAST) && (ch_cnt == CH_LAST);
   assign busy      = (state != ACCUM) || (pix_cnt != '0) || (ch_cnt != '0);

   always_comb begin
      in_ext = ACC_W'(in_data);
      if (SIGNED != 0)
         in_ext = ACC_W'($signed(in_data));
   end

   // Floor division on a sign/magnitude split: a negative numerator rounds its
   // magnitude up so the quotient lands toward minus infinity.
   always_comb begin
      num = NUM_W'(acc[out_idx]);
      if (SIGNED != 0)
         num = NUM_W'($signed(acc[out_idx]));
      if (ROUND != 0)
         num = (num << 1) + NUM_W'(N);
      neg     = (SIGNED != 0) && num[NUM_W-1];
      mag     = neg ? (~num + NUM_W'(1)) : num;
      quo_mag = (neg ? (mag + DEN - NUM_W'(1)) : mag) / DEN;
      avg     = DATA_WIDTH'(neg ? (~quo_mag + NUM_W'(1)) : quo_mag);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ACCUM: if (accept && last_elem) state_nxt = CALC;
         CALC:  state_nxt = OUT;
         OUT:   if (out_ready) state_nxt = (out_idx == CH_LAST) ? ACCUM : CALC;
         default: state_nxt = ACCUM;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= ACCUM;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pix_cnt     <= '0;
         ch_cnt      <= '0;
         out_idx     <= '0;
         out_data    <= '0;
         out_channel <= '0;
         out_last    <= 1'b0;
         for (int i = 0; i < CHANNELS; i++)
            acc[i] <= '0;
      end else begin
         if (accept) begin
            acc[ch_cnt] <= acc[ch_cnt] + in_ext;
            if (last_elem) begin
               pix_cnt <= '0;
               ch_cnt  <= '0;
               out_idx <= '0;
            end else if (CH_ORDER == 0) begin
               if (pix_cnt == PIX_LAST) begin
                  pix_cnt <= '0;
                  ch_cnt  <= ch_cnt + CH_W'(1);
               end else begin
                  pix_cnt <= pix_cnt + PIX_W'(1);
               end
            end else begin
               if (ch_cnt == CH_LAST) begin
                  ch_cnt  <= '0;
                  pix_cnt <= pix_cnt + PIX_W'(1);
               end else begin
                  ch_cnt <= ch_cnt + CH_W'(1);
               end
            end
         end
         // Reading a sum clears it, so the bank is empty when the next frame starts.
         if (state == CALC) begin
            out_data     <= avg;
            out_channel  <= out_idx;
            out_last     <= (out_idx == CH_LAST);
            acc[out_idx] <= '0;
         end
         if ((state == OUT) && out_ready && (out_idx != CH_LAST))
            out_idx <= out_idx + CH_W'(1);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_global_avg_pool_stream.sv
// tb_global_avg_pool_stream: self-checking bench for global_avg_pool_stream.
// Rev 1.0 - 2x2x2 configurations in lockstep plus 3x3x1 signed configurations.
`default_nettype none

module tb_global_avg_pool_stream;

   localparam int A_ORD [4] = '{0, 0, 1, 0};
   localparam int A_SIG [4] = '{0, 0, 1, 1};
   localparam int A_RND [4] = '{0, 1, 0, 1};

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic [15:0] a_in_data;
   logic        a_in_valid, a_out_ready;
   logic [15:0] a_out_data [4];
   logic        a_out_channel [4];
   logic        a_out_last [4], a_out_valid [4], a_in_ready [4], a_busy [4];

   logic [15:0] b_in_data;
   logic        b_in_valid, b_out_ready;
   logic [15:0] b_out_data [2];
   logic        b_out_channel [2];
   logic        b_out_last [2], b_out_valid [2], b_in_ready [2], b_busy [2];

   logic [15:0] fa [8];
   logic [15:0] fb [9];

   for (genvar k = 0; k < 4; k++) begin : g_a
      global_avg_pool_stream #(
         .DATA_WIDTH(16), .IN_HEIGHT(2), .IN_WIDTH(2), .CHANNELS(2),
         .CH_ORDER(A_ORD[k]), .SIGNED(A_SIG[k]), .ROUND(A_RND[k])
      ) dut (
         .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid),
         .in_ready(a_in_ready[k]), .out_data(a_out_data[k]), .out_channel(a_out_channel[k]),
         .out_last(a_out_last[k]), .out_valid(a_out_valid[k]), .out_ready(a_out_ready),
         .busy(a_busy[k])
      );
   end

   for (genvar k = 0; k < 2; k++) begin : g_b
      global_avg_pool_stream #(
         .DATA_WIDTH(16), .IN_HEIGHT(3), .IN_WIDTH(3), .CHANNELS(1),
         .CH_ORDER(0), .SIGNED(1), .ROUND(k)
      ) dut (
         .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid),
         .in_ready(b_in_ready[k]), .out_data(b_out_data[k]), .out_channel(b_out_channel[k]),
         .out_last(b_out_last[k]), .out_valid(b_out_valid[k]), .out_ready(b_out_ready),
         .busy(b_busy[k])
      );
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic longint fdiv(input longint a, input longint b);
      longint q;
      q = a / b;
      if ((a % b != 0) && (a < 0))
         q = q - 1;
      return q;
   endfunction

   function automatic logic [15:0] avg_of(input longint s, input int n, input int rnd);
      longint r;
      r = (rnd != 0) ? fdiv(2 * s + n, 2 * n) : fdiv(s, n);
      return r[15:0];
   endfunction

   // Element i of a 2x2x2 frame belongs to channel i/4 (planar) or i%2 (interleaved).
   function automatic logic [15:0] ref_a(input int k, input int ch);
      longint s = 0;
      for (int i = 0; i < 8; i++) begin
         int c;
         c = (A_ORD[k] != 0) ? (i % 2) : (i / 4);
         if (c == ch)
            s += (A_SIG[k] != 0) ? longint'($signed(fa[i])) : longint'(fa[i]);
      end
      return avg_of(s, 4, A_RND[k]);
   endfunction

   function automatic logic [15:0] ref_b(input int k);
      longint s = 0;
      for (int i = 0; i < 9; i++)
         s += longint'($signed(fb[i]));
      return avg_of(s, 9, k);
   endfunction

   task automatic send_a(input bit gaps);
      for (int i = 0; i < 8; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               a_in_valid = 1'b0;
               a_in_data  = 16'($urandom);
               @(posedge clk); #1;
            end
         end
         a_in_valid = 1'b1;
         a_in_data  = fa[i];
         @(posedge clk); #1;
      end
      a_in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("a_calc_valid", a_out_valid[k], 0);
         check("a_calc_ready", a_in_ready[k], 0);
      end
   endtask

   task automatic drain_a(input int hold);
      // Keep pushing junk while not ready; it must be ignored.
      a_in_valid = 1'b1;
      for (int c = 0; c < 2; c++) begin
         int cnt = 0;
         while (!a_out_valid[0] && cnt < 8) begin
            a_in_data = 16'($urandom);
            @(posedge clk); #1;
            cnt++;
         end
         check("a_latency", cnt, 1);
         for (int k = 0; k < 4; k++) begin
            check("a_valid", a_out_valid[k], 1);
            check("a_data", a_out_data[k], ref_a(k, c));
            check("a_channel", a_out_channel[k], c);
            check("a_last", a_out_last[k], (c == 1));
            check("a_in_ready_low", a_in_ready[k], 0);
            check("a_busy", a_busy[k], 1);
         end
         repeat (hold) begin
            a_in_data = 16'($urandom);
            @(posedge clk); #1;
            for (int k = 0; k < 4; k++) begin
               check("a_hold_valid", a_out_valid[k], 1);
               check("a_hold_data", a_out_data[k], ref_a(k, c));
               check("a_hold_channel", a_out_channel[k], c);
               check("a_hold_ready", a_in_ready[k], 0);
            end
         end
         a_out_ready = 1'b1;
         @(posedge clk); #1;
         a_out_ready = 1'b0;
      end
      a_in_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("a_done_ready", a_in_ready[k], 1);
         check("a_done_valid", a_out_valid[k], 0);
         check("a_done_busy", a_busy[k], 0);
      end
   endtask

   task automatic frame_b(input int hold);
      for (int i = 0; i < 9; i++) begin
         b_in_valid = 1'b1;
         b_in_data  = fb[i];
         @(posedge clk); #1;
      end
      b_in_valid = 1'b0;
      for (int k = 0; k < 2; k++)
         check("b_calc_valid", b_out_valid[k], 0);
      @(posedge clk); #1;
      repeat (hold) begin @(posedge clk); #1; end
      for (int k = 0; k < 2; k++) begin
         check("b_valid", b_out_valid[k], 1);
         check("b_data", b_out_data[k], ref_b(k));
         check("b_channel", b_out_channel[k], 0);
         check("b_last", b_out_last[k], 1);
      end
      b_out_ready = 1'b1;
      @(posedge clk); #1;
      b_out_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         check("b_done_ready", b_in_ready[k], 1);
         check("b_done_busy", b_busy[k], 0);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      a_in_data = '0; a_in_valid = 1'b0; a_out_ready = 1'b0;
      b_in_data = '0; b_in_valid = 1'b0; b_out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) begin
         check("rst_in_ready", a_in_ready[k], 1);
         check("rst_out_valid", a_out_valid[k], 0);
         check("rst_out_data", a_out_data[k], 0);
         check("rst_busy", a_busy[k], 0);
      end
      rst = 1'b1;
      @(posedge clk); #1;

      // Planar reference vector; also pins the model to fixed numbers.
      fa = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd10, 16'd20, 16'd30, 16'd40};
      check("vec_floor_ch0", ref_a(0, 0), 2);
      check("vec_round_ch0", ref_a(1, 0), 3);
      send_a(1'b0);
      drain_a(0);

      // Interleaved reference vector.
      fa = '{16'd1, 16'd10, 16'd2, 16'd20, 16'd3, 16'd30, 16'd4, 16'd40};
      check("vec_inter_ch1", ref_a(2, 1), 25);
      send_a(1'b0);
      drain_a(0);

      // Backpressure followed immediately by a zero frame.
      for (int i = 0; i < 8; i++) fa[i] = 16'd100;
      send_a(1'b0);
      drain_a(5);
      for (int i = 0; i < 8; i++) fa[i] = 16'd0;
      send_a(1'b0);
      drain_a(1);

      // Reset mid-frame discards partial sums.
      a_in_valid = 1'b1;
      a_in_data  = 16'd50;
      repeat (3) begin @(posedge clk); #1; end
      a_in_valid = 1'b0;
      check("mid_busy", a_busy[0], 1);
      rst = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         check("mid_rst_ready", a_in_ready[k], 1);
         check("mid_rst_valid", a_out_valid[k], 0);
         check("mid_rst_data", a_out_data[k], 0);
         check("mid_rst_channel", a_out_channel[k], 0);
         check("mid_rst_last", a_out_last[k], 0);
         check("mid_rst_busy", a_busy[k], 0);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      for (int i = 0; i < 8; i++) fa[i] = 16'd100;
      send_a(1'b0);
      drain_a(0);

      // Randomized frames with input gaps and output stalls.
      for (int f = 0; f < 8; f++) begin
         for (int i = 0; i < 8; i++) fa[i] = 16'($urandom);
         send_a(1'b1);
         drain_a(int'($urandom_range(0, 3)));
      end

      // Signed 3x3x1: -10 then zeros.
      fb[0] = 16'hFFF6;
      for (int i = 1; i < 9; i++) fb[i] = 16'd0;
      check("vec_b_floor", ref_b(0), 16'hFFFE);
      check("vec_b_round", ref_b(1), 16'hFFFF);
      frame_b(0);
      for (int f = 0; f < 5; f++) begin
         for (int i = 0; i < 9; i++) fb[i] = 16'($urandom);
         frame_b(int'($urandom_range(0, 2)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
